sdram_rw_arbiter: RTL

- Upstream stage of the SDRAM interface FSM; the only master of its wr_req/rd_req/rw_addr/wr_data port.
- Moves fixed-length bursts from a show-ahead write FIFO (camera side) into SDRAM, and from SDRAM into a read FIFO (VGA side).
- Generates wrapping linear frame addresses and arbitrates write vs read bursts round-robin.

---
 rtl/sdram_rw_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_rw_arbiter.sv
// Burst arbiter feeding the SDRAM interface: write FIFO -> SDRAM and SDRAM -> read FIFO,
// with round-robin grant and wrapping frame addresses. Optional macro SDRAM_PINGPONG_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no burst active; pick write or read for the next burst
// ST_WR_REQ  | write request held until the interface acks
// ST_WR_DATA | popping write FIFO words on each ack cycle
// ST_RD_REQ  | read request held until the interface acks
// ST_RD_DATA | counting returned read words into the read FIFO
module sdram_rw_arbiter #(
    parameter int BURST_LEN     = 8,
    parameter int FRAME_WORDS   = 307200,
    parameter int RD_FIFO_DEPTH = 512,
    parameter int FIFO_UW       = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FIFO_UW-1:0] wr_fifo_usedw,
    input  logic [15:0]        wr_fifo_rdata,
    output logic               wr_fifo_rd,
    input  logic [FIFO_UW-1:0] rd_fifo_usedw,
    output logic               rd_fifo_wr,
    output logic [15:0]        rd_fifo_wdata,
    input  logic               rd_enable,
    output logic               intf_wr_req,
    output logic               intf_rd_req,
    output logic [24:0]        intf_rw_addr,
    output logic [15:0]        intf_wr_data,
    input  logic               intf_ack,
    input  logic [15:0]        intf_rd_data,
    input  logic               intf_rd_data_vld,
    output logic               wr_frame_done,
    output logic               rd_frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_RD_REQ,
        ST_RD_DATA
    } state_t;

    localparam int                 BEAT_W     = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0]  BEATS_FULL = BEAT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0]  BEAT_ONE   = BEAT_W'(1);
    localparam logic [FIFO_UW-1:0] WR_MIN     = FIFO_UW'(BURST_LEN);
    localparam logic [FIFO_UW-1:0] RD_MAX     = FIFO_UW'(RD_FIFO_DEPTH - BURST_LEN);
    localparam logic [22:0]        ADDR_STEP  = 23'(BURST_LEN);
    localparam logic [22:0]        ADDR_LAST  = 23'(FRAME_WORDS - BURST_LEN);

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    logic [22:0]         wr_addr_q, wr_addr_d;
    logic [22:0]         rd_addr_q, rd_addr_d;
    logic                last_wr_q, last_wr_d;
    logic                wr_req_q, wr_req_d;
    logic                rd_req_q, rd_req_d;
    logic                wr_done_q, wr_done_d;
    logic                rd_done_q, rd_done_d;

`ifdef SDRAM_PINGPONG_EN
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic                full_bank_q, full_bank_d;
`endif

    logic wr_ok, rd_ok, wr_side, rd_side, wr_pop, rd_beat, wr_wrap, rd_wrap;
    logic [1:0] bank_sel;

    assign wr_ok   = (wr_fifo_usedw >= WR_MIN);
    assign rd_ok   = rd_enable && (rd_fifo_usedw <= RD_MAX);
    assign wr_side = (state_q == ST_WR_REQ) || (state_q == ST_WR_DATA);
    assign rd_side = (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    assign wr_pop  = intf_ack && wr_side;
    assign rd_beat = intf_rd_data_vld && rd_side;
    assign wr_wrap = (wr_addr_q == ADDR_LAST);
    assign rd_wrap = (rd_addr_q == ADDR_LAST);

    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        last_wr_d = last_wr_q;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
`ifdef SDRAM_PINGPONG_EN
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_bank_d = full_bank_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // last_wr_q clear after reset, so write wins the first tie
                if (wr_ok && (!rd_ok || !last_wr_q)) begin
                    state_d   = ST_WR_REQ;
                    last_wr_d = 1'b1;
                    beats_d   = BEATS_FULL;
                end else if (rd_ok) begin
                    state_d   = ST_RD_REQ;
                    last_wr_d = 1'b0;
                    beats_d   = BEATS_FULL;
                end
            end
            ST_WR_REQ, ST_WR_DATA: begin
                if (wr_pop) begin
                    beats_d = beats_q - BEAT_ONE;
                    if (beats_q == BEAT_ONE) begin
                        state_d   = ST_IDLE;
                        wr_addr_d = wr_wrap ? '0 : wr_addr_q + ADDR_STEP;
                        wr_done_d = wr_wrap;
`ifdef SDRAM_PINGPONG_EN
                        if (wr_wrap) begin
                            full_bank_d = wr_bank_q;
                            wr_bank_d   = ~wr_bank_q;
                        end
`endif
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end
            end
            ST_RD_REQ, ST_RD_DATA: begin
                if (rd_beat) begin
                    beats_d = beats_q - BEAT_ONE;
                end
                if (rd_beat && (beats_q == BEAT_ONE)) begin
                    state_d   = ST_IDLE;
                    rd_addr_d = rd_wrap ? '0 : rd_addr_q + ADDR_STEP;
                    rd_done_d = rd_wrap;
`ifdef SDRAM_PINGPONG_EN
                    if (rd_wrap) begin
                        rd_bank_d = full_bank_q;
                    end
`endif
                end else if ((state_q == ST_RD_REQ) && intf_ack) begin
                    state_d = ST_RD_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wr_req_d = (state_d == ST_WR_REQ);
        rd_req_d = (state_d == ST_RD_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            beats_q   <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            last_wr_q <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            last_wr_q <= last_wr_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
        end
    end

`ifdef SDRAM_PINGPONG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b1;
            full_bank_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_bank_q <= full_bank_d;
        end
    end

    assign bank_sel = wr_side ? {1'b0, wr_bank_q} :
                      rd_side ? {1'b0, rd_bank_q} : 2'b00;
`else
    assign bank_sel = 2'b00;
`endif

    assign intf_wr_req   = wr_req_q;
    assign intf_rd_req   = rd_req_q;
    assign intf_rw_addr  = {bank_sel, (wr_side ? wr_addr_q : rd_addr_q)};
    assign intf_wr_data  = wr_fifo_rdata;
    assign wr_fifo_rd    = wr_pop;
    assign rd_fifo_wr    = intf_rd_data_vld;
    assign rd_fifo_wdata = intf_rd_data;
    assign wr_frame_done = wr_done_q;
    assign rd_frame_done = rd_done_q;

endmodule
